// File: rtl/wb_cfg_loader_if.sv
// Bundle of the loader's stream, step handshake and register/SRAM port signals.
// The master modport is the loader; the slave modport is the environment.
interface wb_cfg_loader_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [AXI_DATA_WIDTH-1:0] s_axis_tdata;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic                      s_axis_tlast;
    logic                      step_valid;
    logic                      step_ready;
    logic                      reg_wr_en;
    logic [AXI_ADDR_WIDTH-1:0] reg_wr_addr;
    logic [AXI_DATA_WIDTH-1:0] reg_wr_data;
    logic                      reg_rd_en;
    logic [AXI_ADDR_WIDTH-1:0] reg_rd_addr;
    logic [AXI_DATA_WIDTH-1:0] reg_rd_data;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, step_valid, reg_rd_data,
        output s_axis_tready, step_ready, reg_wr_en, reg_wr_addr, reg_wr_data,
               reg_rd_en, reg_rd_addr
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, step_valid, reg_rd_data,
        input  s_axis_tready, step_ready, reg_wr_en, reg_wr_addr, reg_wr_data,
               reg_rd_en, reg_rd_addr
    );
endinterface

// File: rtl/wb_cfg_loader.sv
// Writeback configuration loader: streams bundle descriptors into the SRAM window,
// starts the writeback block, then runs EN_COUNT/READY/IB count-step handshakes.
module wb_cfg_loader #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned SRAM_RD_DEPTH  = 8,
    parameter int unsigned N_REG          = 32,
    parameter int unsigned VAR_PER_ROW    = 5
) (
    input  logic              clk,
    input  logic              rstn,
    wb_cfg_loader_if.master   bus,
    output logic [31:0]       cur_ib,
    output logic              busy,
    output logic              err
);
    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned DW = AXI_DATA_WIDTH;

    localparam logic [AW-1:0] A_START = AW'(0);
    localparam logic [AW-1:0] A_N1    = AW'(1);
    localparam logic [AW-1:0] A_EN    = AW'(2);
    localparam logic [AW-1:0] A_READY = AW'(3);
    localparam logic [AW-1:0] A_IB    = AW'(4);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SET_N, S_START, S_RUN,
        S_STEP, S_POLL, S_CLR, S_RD_IB, S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] n1_q, n1_d, k_q, k_d, cur_ib_d;
    logic        err_d;
    logic [1:0]  rst_sync;
    logic        rst_int_n;

    logic          tready, step_rdy, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

    // Reset asserts asynchronously and is released on a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [31:0] hdr_n1, exp_cnt, k_inc;
    logic        hdr_bad, load_last;
    state_t      hdr_next;

    assign hdr_n1    = 32'(bus.s_axis_tdata);
    assign hdr_bad   = bus.s_axis_tlast || (hdr_n1 >= 32'(SRAM_RD_DEPTH));
    assign hdr_next  = bus.s_axis_tlast ? S_IDLE : (hdr_bad ? S_DRAIN : S_LOAD);
    assign exp_cnt   = (n1_q + 32'd1) * 32'(VAR_PER_ROW);
    assign k_inc     = k_q + 32'd1;
    assign load_last = (k_inc == exp_cnt);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
            n1_q    <= '0;
            k_q     <= '0;
            err     <= 1'b0;
            cur_ib  <= '0;
        end else begin
            state_q <= state_d;
            n1_q    <= n1_d;
            k_q     <= k_d;
            err     <= err_d;
            cur_ib  <= cur_ib_d;
        end
    end

    // Next state and same-cycle bus strobes; addresses/data stay 0 outside strobes.
    always_comb begin
        state_d  = state_q;
        n1_d     = n1_q;
        k_d      = k_q;
        err_d    = err;
        cur_ib_d = cur_ib;
        tready   = 1'b0;
        step_rdy = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        case (state_q)
            S_IDLE: begin
                tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    n1_d    = hdr_n1;
                    k_d     = '0;
                    err_d   = hdr_bad;
                    state_d = hdr_next;
                end
            end
            S_LOAD: begin
                tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(N_REG) + AW'(k_q);
                    wr_data = bus.s_axis_tdata;
                    k_d     = k_inc;
                    if (bus.s_axis_tlast) begin
                        err_d   = !load_last;
                        state_d = load_last ? S_SET_N : S_IDLE;
                    end else if (load_last) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_SET_N: begin
                wr_en   = 1'b1;
                wr_addr = A_N1;
                wr_data = DW'(n1_q);
                state_d = S_START;
            end
            S_START: begin
                wr_en   = 1'b1;
                wr_addr = A_START;
                wr_data = DW'(1);
                state_d = S_RUN;
            end
            S_RUN: begin
                step_rdy = 1'b1;
                // A pending step stalls the stream for this cycle.
                if (bus.step_valid) begin
                    state_d = S_STEP;
                end else begin
                    tready = 1'b1;
                    if (bus.s_axis_tvalid) begin
                        n1_d    = hdr_n1;
                        k_d     = '0;
                        err_d   = hdr_bad;
                        state_d = hdr_next;
                    end
                end
            end
            S_STEP: begin
                wr_en   = 1'b1;
                wr_addr = A_EN;
                wr_data = DW'(1);
                state_d = S_POLL;
            end
            S_POLL: begin
                rd_en   = 1'b1;
                rd_addr = A_READY;
                if (bus.reg_rd_data[0]) state_d = S_CLR;
            end
            S_CLR: begin
                wr_en   = 1'b1;
                wr_addr = A_READY;
                wr_data = '0;
                state_d = S_RD_IB;
            end
            S_RD_IB: begin
                rd_en    = 1'b1;
                rd_addr  = A_IB;
                cur_ib_d = 32'(bus.reg_rd_data);
                state_d  = S_RUN;
            end
            S_DRAIN: begin
                tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.s_axis_tready = tready && rst_int_n;
    assign bus.step_ready    = step_rdy;
    assign bus.reg_wr_en     = wr_en;
    assign bus.reg_wr_addr   = wr_addr;
    assign bus.reg_wr_data   = wr_data;
    assign bus.reg_rd_en     = rd_en;
    assign bus.reg_rd_addr   = rd_addr;
    assign busy              = (state_q != S_IDLE) && (state_q != S_RUN);
endmodule

// File: doc/wb_cfg_loader.md
# wb_cfg_loader

Initiator side of the writeback register/SRAM port. It consumes a 32-bit AXI-Stream program of bundle descriptors and writes them into the writeback SRAM window. It then programs the bundle count and pulses START. After that it serves count-step requests: it writes EN_COUNT, polls READY, clears READY, and reads back the bundle index. It sits between the DMA/PS stream and the writeback block, in place of direct PS register pokes.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, width of reg_wr_addr / reg_rd_addr
- AXI_DATA_WIDTH, 32, width of reg data and stream data
- SRAM_RD_DEPTH, 8, max bundles; header n_bundles_1 must be < SRAM_RD_DEPTH
- N_REG, 32, register window size; SRAM words start at address N_REG
- VAR_PER_ROW, 5, 32-bit descriptor words per bundle

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  AXI_DATA_WIDTH  program words
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  last word of program
- step_valid  in  1  request one count step
- step_ready  out  1  loader can accept a step
- reg_wr_en  out  1  register/SRAM write strobe
- reg_wr_addr  out  AXI_ADDR_WIDTH  write address (word units)
- reg_wr_data  out  AXI_DATA_WIDTH  write data
- reg_rd_en  out  1  read strobe
- reg_rd_addr  out  AXI_ADDR_WIDTH  read address
- reg_rd_data  in  AXI_DATA_WIDTH  read data, valid combinationally in the same cycle as reg_rd_en
- cur_ib  out  32  bundle index read after the last completed step
- busy  out  1  high in every state except IDLE and RUN
- err  out  1  sticky program-format error; cleared by the next accepted header

## Operation
- Register map driven: START=0, N_BUNDLES_1=1, EN_COUNT=2, READY=3, IB=4.
- Program format: word0 = n_bundles_1. It is followed by exactly (n_bundles_1+1)*VAR_PER_ROW descriptor words, with tlast on the final one.
- States: IDLE, LOAD, SET_N, START, RUN, STEP, POLL, CLR, RD_IB, DRAIN.
- IDLE: tready=1. A header beat stores n1, clears err and the word counter k, then goes to LOAD.
  - tlast on the header, or n1 >= SRAM_RD_DEPTH, sets err and goes to IDLE (tlast) or DRAIN (otherwise).
- LOAD: tready=1 and reg_wr_en = tvalid. The write is issued in the same cycle as the handshake, to address N_REG+k, with data = tdata. k increments per beat.
  - The expected last word with tlast goes to SET_N.
  - tlast early sets err and goes to IDLE.
  - The expected last word without tlast sets err and goes to DRAIN.
- SET_N: write addr 1 = n1, then go to START.
- START: write addr 0 = 1, then go to RUN.
- RUN: step_ready=1 and tready=1.
  - step_valid wins over tvalid: a step goes to STEP and the stream stalls that cycle.
  - Otherwise a stream beat is treated as a new header, with the same rules as IDLE.
- STEP: write addr 2 = 1, then go to POLL.
- POLL: reg_rd_en=1, addr 3, every cycle until reg_rd_data[0]=1, then go to CLR. There is no timeout.
- CLR: write addr 3 = 0, then go to RD_IB.
- RD_IB: read addr 4, capture into cur_ib, then go to RUN.
- DRAIN: tready=1 and no writes; tlast goes to IDLE.
- Arithmetic: k is 32 bits. The expected count is computed in 32 bits as (n1+1)*VAR_PER_ROW (max 40 with defaults), so it never wraps.

## Timing
- Reset (async assert, sync deassert internally): state=IDLE, and every output is 0 (tready, step_ready, reg_* strobes, addresses, data, cur_ib, busy, err).
- At most one reg write or one reg read per cycle, never both.
- Write and read strobes are single-cycle, and their address/data are valid in the same cycle. Outside strobes, address/data are held at 0.
- LOAD is full throughput: one word per clk. Header to first SRAM write: 1 cycle.
- Last load word to START write: 2 cycles (SET_N, then START). step_ready rises the cycle after START.
- Step latency = 1 (STEP) + poll cycles + 1 (CLR) + 1 (RD_IB). cur_ib updates at the end of RD_IB, and step_ready returns the next cycle.
- step_ready is low from the cycle after a step is accepted until the step finishes.
- rstn asserted mid-operation aborts immediately. No partial write completes after reset, and the responder contents are unspecified.

## Test plan
- Load, n1=1, 10 words D0..D9 with tlast on D9 -> writes addr 32..41 = D0..D9 in 10 consecutive cycles, then addr1=1, then addr0=1; step_ready=1; err=0.
- Step: responder raises READY 3 cycles after the EN_COUNT write, IB=1 -> write addr2=1, 3 polls of addr3, write addr3=0, read addr4; cur_ib=1.
- Early tlast on word 4 of 10 -> 5 SRAM writes, err=1, IDLE, no SET_N/START writes. The next valid program clears err.
- Header n1=8 (SRAM_RD_DEPTH=8) with 3 trailing words, the last with tlast -> err=1, no writes, all 3 drained, IDLE.
- In RUN, step_valid and tvalid in the same cycle -> step taken, tready=0 that cycle. The header is accepted only after RD_IB.
- rstn pulled low during POLL -> all outputs 0 within the same cycle, state IDLE. After release, a fresh program loads normally.
